// File: rtl/imem_boot_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_boot_loader
// Description : Receives a length-prefixed, XOR-checksummed byte stream,
//               packs it into 32-bit words for instruction memory and releases
//               the core once the whole image has been loaded and verified.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_boot_loader #(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              reload,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_run,
    output logic              done,
    output logic              err,
    output logic [5:0]        word_cnt
);

    typedef enum logic [2:0] {
        S_LEN   = 3'd0,
        S_BYTE  = 3'd1,
        S_WRITE = 3'd2,
        S_CHK   = 3'd3,
        S_RUN   = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    localparam logic [8:0] DEPTH_B = 9'(DEPTH);

    state_t      state;
    state_t      state_next;
    logic [5:0]  len;
    logic [1:0]  lane;
    logic [7:0]  csum;
    logic [31:0] word_buf;

    logic        xfer;
    logic        len_bad;
    logic [5:0]  wcnt_inc;
    logic [ADDR_W+7:0] addr_full;

    assign xfer      = in_valid & in_ready;
    assign len_bad   = (in_data == 8'd0) || ({1'b0, in_data} > DEPTH_B);
    assign wcnt_inc  = word_cnt + 6'd1;
    assign addr_full = {{ADDR_W{1'b0}}, word_cnt, 2'b00};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_LEN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_LEN: begin
                if (xfer) begin
                    state_next = len_bad ? S_ERR : S_BYTE;
                end
            end
            S_BYTE: begin
                if (xfer && (lane == 2'd3)) begin
                    state_next = S_WRITE;
                end
            end
            S_WRITE: begin
                state_next = (wcnt_inc == len) ? S_CHK : S_BYTE;
            end
            S_CHK: begin
                if (xfer) begin
                    state_next = (in_data == csum) ? S_RUN : S_ERR;
                end
            end
            S_RUN, S_ERR: begin
                if (reload) begin
                    state_next = S_LEN;
                end
            end
            default: state_next = S_LEN;
        endcase
    end

    // All outputs are decoded from registered state only.
    always_comb begin
        in_ready   = 1'b0;
        imem_we    = 1'b0;
        imem_addr  = '0;
        imem_wdata = 32'd0;
        cpu_run    = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
        case (state)
            S_LEN, S_BYTE, S_CHK: in_ready = 1'b1;
            S_WRITE: begin
                imem_we    = 1'b1;
                imem_addr  = addr_full[ADDR_W-1:0];
                imem_wdata = word_buf;
            end
            S_RUN: begin
                cpu_run = 1'b1;
                done    = 1'b1;
            end
            S_ERR:   err = 1'b1;
            default: in_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            len      <= 6'd0;
            lane     <= 2'd0;
            csum     <= 8'd0;
            word_buf <= 32'd0;
            word_cnt <= 6'd0;
        end else begin
            case (state)
                S_LEN: begin
                    if (xfer && !len_bad) begin
                        len      <= in_data[5:0];
                        lane     <= 2'd0;
                        csum     <= 8'd0;
                        word_cnt <= 6'd0;
                    end
                end
                S_BYTE: begin
                    if (xfer) begin
                        word_buf[{lane, 3'b000} +: 8] <= in_data;
                        csum <= csum ^ in_data;
                        lane <= lane + 2'd1;
                    end
                end
                S_WRITE: begin
                    word_cnt <= wcnt_inc;
                end
                S_RUN, S_ERR: begin
                    // A reload starts a fresh image, so no words written yet.
                    if (reload) begin
                        word_cnt <= 6'd0;
                    end
                end
                default: begin
                    len <= len;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
